// File: rtl/ahb_soc_pkg.sv
// Shared AHB-Lite SoC definitions: transfer encodings, decoder select codes,
// slave count and the default-slave state enum.
package ahb_soc_pkg;

  localparam int unsigned NUM_SLAVES = 10;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned CNT_W      = 8;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [SEL_W-1:0] MUX_SEL_NOMAP = 4'hF;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // True for transfers that need a real response (NONSEQ/SEQ).
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic act;
    case (htrans)
      HTRANS_IDLE:   act = 1'b0;
      HTRANS_BUSY:   act = 1'b0;
      HTRANS_NONSEQ: act = 1'b1;
      HTRANS_SEQ:    act = 1'b1;
      default:       act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response FSM plus a
// saturating count of errors issued.
// Ports: clk_i/rst_ni (sync active-low), hready_i (system HREADY), hsel_i
// (unmapped select), htrans_i; ready_c_o/resp_c_o combinational from state,
// errcnt_o registered.
module ahb_default_slave
  import ahb_soc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hready_i,
  input  logic             hsel_i,
  input  logic [1:0]       htrans_i,
  output logic             ready_c_o,
  output logic             resp_c_o,
  output logic [CNT_W-1:0] errcnt_o
);

  ds_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= DS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. ERR2 has HREADY=1, so its address phase is sampled directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (hready_i && hsel_i && htrans_active(htrans_i)) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = (hsel_i && htrans_active(htrans_i)) ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  // ERR1 is only ever entered from another state, so state_d==ERR1 marks entry.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == DS_ERR1) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Response outputs.
  always_comb begin
    ready_c_o = 1'b1;
    resp_c_o  = 1'b0;
    case (state_q)
      DS_ERR1: begin
        ready_c_o = 1'b0;
        resp_c_o  = 1'b1;
      end
      DS_ERR2: resp_c_o = 1'b1;
      default: ;
    endcase
  end

  assign errcnt_o = cnt_q;

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite slave-to-master multiplexor with integrated default slave.
// Ports: HCLK/HRESETn (sync active-low); HTRANS, HSEL_NOMAP, MUX_SEL from the
// decoder/master; HRDATA_Sx/HREADYOUT_Sx/HRESP_Sx from slaves S0..S9;
// HRDATA/HREADY/HRESP to the master (HREADY is the system HREADY);
// NOMAP_ERRCNT counts default-slave ERROR responses.
module ahb_slave_mux
  import ahb_soc_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] NOMAP_DATA = 32'hDEAD_BEEF
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [1:0]        HTRANS,
  input  logic              HSEL_NOMAP,
  input  logic [SEL_W-1:0]  MUX_SEL,
  input  logic [DATA_W-1:0] HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3, HRDATA_S4,
  input  logic [DATA_W-1:0] HRDATA_S5, HRDATA_S6, HRDATA_S7, HRDATA_S8, HRDATA_S9,
  input  logic              HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
  input  logic              HREADYOUT_S4, HREADYOUT_S5, HREADYOUT_S6, HREADYOUT_S7,
  input  logic              HREADYOUT_S8, HREADYOUT_S9,
  input  logic              HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3, HRESP_S4,
  input  logic              HRESP_S5, HRESP_S6, HRESP_S7, HRESP_S8, HRESP_S9,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADY,
  output logic              HRESP,
  output logic [CNT_W-1:0]  NOMAP_ERRCNT
);

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] slv_rdata [NUM_SLAVES];
  logic              slv_ready [NUM_SLAVES];
  logic              slv_resp  [NUM_SLAVES];
  logic              ds_ready_c, ds_resp_c;

  assign slv_rdata = '{HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3, HRDATA_S4,
                       HRDATA_S5, HRDATA_S6, HRDATA_S7, HRDATA_S8, HRDATA_S9};
  assign slv_ready = '{HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3, HREADYOUT_S4,
                       HREADYOUT_S5, HREADYOUT_S6, HREADYOUT_S7, HREADYOUT_S8, HREADYOUT_S9};
  assign slv_resp  = '{HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3, HRESP_S4,
                       HRESP_S5, HRESP_S6, HRESP_S7, HRESP_S8, HRESP_S9};

  // Data-phase select: captured only when the system accepts an address phase.
  assign sel_d = HREADY ? MUX_SEL : sel_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) sel_q <= MUX_SEL_NOMAP;
    else          sel_q <= sel_d;
  end

  ahb_default_slave u_default_slave (
    .clk_i     (HCLK),
    .rst_ni    (HRESETn),
    .hready_i  (HREADY),
    .hsel_i    (HSEL_NOMAP),
    .htrans_i  (HTRANS),
    .ready_c_o (ds_ready_c),
    .resp_c_o  (ds_resp_c),
    .errcnt_o  (NOMAP_ERRCNT)
  );

  // Steering mux; any code outside 0..9 falls through to the default slave.
  always_comb begin
    HRDATA = NOMAP_DATA;
    HREADY = ds_ready_c;
    HRESP  = ds_resp_c;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel_q == SEL_W'(i)) begin
        HRDATA = slv_rdata[i];
        HREADY = slv_ready[i];
        HRESP  = slv_resp[i];
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Scoreboard bench for ahb_slave_mux: stimulus pushes hand-computed expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_ahb_slave_mux;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [1:0]  HTRANS;
  logic        HSEL_NOMAP;
  logic [3:0]  MUX_SEL;
  logic [31:0] rd  [10];
  logic        rdy [10];
  logic        rsp [10];
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [7:0]  NOMAP_ERRCNT;

  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        rdy;
    logic        rsp;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_slave_mux dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HTRANS(HTRANS), .HSEL_NOMAP(HSEL_NOMAP), .MUX_SEL(MUX_SEL),
    .HRDATA_S0(rd[0]), .HRDATA_S1(rd[1]), .HRDATA_S2(rd[2]), .HRDATA_S3(rd[3]), .HRDATA_S4(rd[4]),
    .HRDATA_S5(rd[5]), .HRDATA_S6(rd[6]), .HRDATA_S7(rd[7]), .HRDATA_S8(rd[8]), .HRDATA_S9(rd[9]),
    .HREADYOUT_S0(rdy[0]), .HREADYOUT_S1(rdy[1]), .HREADYOUT_S2(rdy[2]), .HREADYOUT_S3(rdy[3]),
    .HREADYOUT_S4(rdy[4]), .HREADYOUT_S5(rdy[5]), .HREADYOUT_S6(rdy[6]), .HREADYOUT_S7(rdy[7]),
    .HREADYOUT_S8(rdy[8]), .HREADYOUT_S9(rdy[9]),
    .HRESP_S0(rsp[0]), .HRESP_S1(rsp[1]), .HRESP_S2(rsp[2]), .HRESP_S3(rsp[3]), .HRESP_S4(rsp[4]),
    .HRESP_S5(rsp[5]), .HRESP_S6(rsp[6]), .HRESP_S7(rsp[7]), .HRESP_S8(rsp[8]), .HRESP_S9(rsp[9]),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .NOMAP_ERRCNT(NOMAP_ERRCNT)
  );

  // Push the expectation for the current cycle, then advance past the next edge.
  task automatic cyc(input string nm, input logic [31:0] ed, input logic er,
                     input logic ep, input logic [7:0] ec);
    exp_t e;
    e.name = nm; e.d = ed; e.rdy = er; e.rsp = ep; e.cnt = ec;
    exp_q.push_back(e);
    @(posedge HCLK);
    #1;
  endtask

  // Monitor: compares outputs mid-cycle against the oldest expectation.
  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (HRDATA !== e.d || HREADY !== e.rdy || HRESP !== e.rsp || NOMAP_ERRCNT !== e.cnt) begin
        n_errors++;
        $display("FAIL %s: got d=%h rdy=%b rsp=%b cnt=%0d, want d=%h rdy=%b rsp=%b cnt=%0d",
                 e.name, HRDATA, HREADY, HRESP, NOMAP_ERRCNT, e.d, e.rdy, e.rsp, e.cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; HTRANS = 2'b00; HSEL_NOMAP = 1'b0; MUX_SEL = 4'hF;
    for (int i = 0; i < 10; i++) begin
      rd[i] = 32'hA0A0_0000 + 32'(i); rdy[i] = 1'b1; rsp[i] = 1'b0;
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Reset state, then a mapped read to S3 with MUX_SEL changing mid data phase.
    MUX_SEL = 4'd3; rd[3] = 32'h1234_5678;
    cyc("reset", DB, 1'b1, 1'b0, 8'd0);
    MUX_SEL = 4'd5;
    cyc("map_rd_s3", 32'h1234_5678, 1'b1, 1'b0, 8'd0);
    MUX_SEL = 4'd1; rsp[5] = 1'b1;
    cyc("sel_s5_resp", 32'hA0A0_0005, 1'b1, 1'b1, 8'd0);
    rsp[5] = 1'b0;

    // Wait states on S1 freeze sel_q; release loads 5.
    MUX_SEL = 4'd5; rdy[1] = 1'b0;
    cyc("ws1", 32'hA0A0_0001, 1'b0, 1'b0, 8'd0);
    cyc("ws2", 32'hA0A0_0001, 1'b0, 1'b0, 8'd0);
    rdy[1] = 1'b1;
    cyc("ws_end", 32'hA0A0_0001, 1'b1, 1'b0, 8'd0);

    // Unmapped NONSEQ issued while S5 data phase completes.
    MUX_SEL = 4'hF; HSEL_NOMAP = 1'b1; HTRANS = 2'b10;
    cyc("s5_after_ws", 32'hA0A0_0005, 1'b1, 1'b0, 8'd0);
    HTRANS = 2'b00;
    cyc("err1", DB, 1'b0, 1'b1, 8'd1);
    cyc("err2", DB, 1'b1, 1'b1, 8'd1);
    cyc("nomap_idle", DB, 1'b1, 1'b0, 8'd1);
    HTRANS = 2'b01;
    cyc("nomap_busy", DB, 1'b1, 1'b0, 8'd1);

    // Back-to-back unmapped SEQ through saturation of the counter.
    HTRANS = 2'b10;
    cyc("idle_nonseq", DB, 1'b1, 1'b0, 8'd1);
    HTRANS = 2'b11;
    for (int k = 2; k <= 258; k++) begin
      cyc("b2b_err1", DB, 1'b0, 1'b1, (k > 255) ? 8'd255 : 8'(k));
      cyc("b2b_err2", DB, 1'b1, 1'b1, (k > 255) ? 8'd255 : 8'(k));
    end

    // Now in ERR1 with a saturated counter; reset there.
    HRESETn = 1'b0;
    cyc("pre_rst_err1", DB, 1'b0, 1'b1, 8'd255);
    HRESETn = 1'b1; HTRANS = 2'b00; HSEL_NOMAP = 1'b0; MUX_SEL = 4'd2;
    cyc("post_rst_err1", DB, 1'b1, 1'b0, 8'd0);
    rdy[2] = 1'b0; HRESETn = 1'b0;
    cyc("pre_rst_ws", 32'hA0A0_0002, 1'b0, 1'b0, 8'd0);
    rdy[2] = 1'b1; HRESETn = 1'b1; MUX_SEL = 4'hC;
    cyc("post_rst_ws", DB, 1'b1, 1'b0, 8'd0);
    MUX_SEL = 4'd9;
    cyc("code12", DB, 1'b1, 1'b0, 8'd0);
    cyc("sel_s9", 32'hA0A0_0009, 1'b1, 1'b0, 8'd0);

    @(posedge HCLK); #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
